// File: rtl/scan_counter_display_pkg.sv
// Shared constants for the scanned counter display: digit width, dead-time
// ratio and the 7-segment patterns (bit0=a .. bit6=g, active high).
package scan_counter_display_pkg;

  localparam int DIGIT_W         = 4;
  // Dead time is the first 1/2**DEAD_RATIO_LOG2 of each digit dwell.
  localparam int DEAD_RATIO_LOG2 = 3;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Saturate a loaded digit to the largest legal BCD value.
  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/scan_counter_display_seg7_decode.sv
// Combinational hex digit to 7-segment pattern decoder.
module seg7_decode
  import scan_counter_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [6:0]         seg
);

  // Pattern lookup for all sixteen digit codes.
  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/scan_counter_display.sv
// Up/down hex or BCD counter with a tick divider and a multiplexed
// 7-segment display driver (dead time between digits, leading-zero blanking).
module scan_counter_display
  import scan_counter_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 16000000,
  parameter int SCAN_LOG2  = 12,
  parameter int DECIMAL    = 0
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          EN,
  input  logic                          UP,
  input  logic                          LOAD,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] LOAD_VAL,
  input  logic                          BLANK_LZ,
  output logic [6:0]                    SEG,
  output logic [NUM_DIGITS-1:0]         COMM,
  output logic [DIGIT_W*NUM_DIGITS-1:0] VALUE,
  output logic                          TICK
);

  localparam int VW    = DIGIT_W * NUM_DIGITS;
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]           div_cnt;
  logic [VW-1:0]              count_q;
  logic [VW-1:0]              count_step;
  logic [VW-1:0]              load_eff;
  logic                       tick;
  logic [SCAN_LOG2-1:0]       dwell_cnt;
  logic [IDX_W-1:0]           scan_idx;
  logic                       dead;
  logic [NUM_DIGITS-1:0]      lz_blank;
  logic                       lz_run;
  logic [DIGIT_W-1:0]         cur_digit;
  logic                       cur_blank;
  logic [6:0]                 cur_seg;
  logic                       carry;
  logic [DIGIT_W-1:0]         dig;

  // TICK is decoded straight from the divider so it lines up with the step edge.
  assign tick  = EN && (div_cnt == DIV_LAST);
  assign TICK  = tick;
  assign VALUE = count_q;

  // Next count for one step: binary +/-1, or per-digit BCD ripple.
  always_comb begin
    count_step = count_q;
    carry      = 1'b1;
    dig        = '0;
    if (DECIMAL != 0) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig = count_q[i*DIGIT_W +: DIGIT_W];
        if (carry) begin
          if (UP) begin
            if (dig >= 4'd9) dig = 4'd0;
            else begin
              dig   = dig + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (dig == 4'd0) dig = 4'd9;
            else begin
              dig   = dig - 4'd1;
              carry = 1'b0;
            end
          end
        end
        count_step[i*DIGIT_W +: DIGIT_W] = dig;
      end
    end else begin
      count_step = UP ? (count_q + VW'(1)) : (count_q - VW'(1));
    end
  end

  // Load value, with out-of-range digits saturated in BCD mode.
  always_comb begin
    load_eff = LOAD_VAL;
    if (DECIMAL != 0) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        load_eff[i*DIGIT_W +: DIGIT_W] = bcd_clamp(LOAD_VAL[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Divider and count: LOAD wins over a coincident tick and restarts the divider.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
      count_q <= '0;
    end else if (LOAD) begin
      div_cnt <= '0;
      count_q <= load_eff;
    end else if (tick) begin
      div_cnt <= '0;
      count_q <= count_step;
    end else if (EN) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Dwell timer and digit index; runs regardless of EN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dwell_cnt <= '0;
      scan_idx  <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + SCAN_LOG2'(1);
      if (&dwell_cnt)
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
    end
  end

  assign dead = (dwell_cnt[SCAN_LOG2-1 -: DEAD_RATIO_LOG2] == '0);

  // Digit i>0 blanks when it and every higher digit are zero; digit 0 never blanks.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run      = lz_run && (count_q[i*DIGIT_W +: DIGIT_W] == 4'd0);
      lz_blank[i] = lz_run;
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        cur_digit = count_q[i*DIGIT_W +: DIGIT_W];
        cur_blank = lz_blank[i];
      end
    end
  end

  seg7_decode u_seg7_decode (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  // Registered drive: commons released during dead time, one common low otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SEG  <= SEG_BLANK;
      COMM <= '1;
    end else begin
      SEG  <= (BLANK_LZ && cur_blank) ? SEG_BLANK : cur_seg;
      COMM <= dead ? '1 : ~(NUM_DIGITS'(1) << scan_idx);
    end
  end

endmodule

// File: tb/tb_scan_counter_display.sv
// Bench for scan_counter_display: scoreboard on VALUE after every TICK/LOAD,
// plus directed checks of scan timing, segment patterns, blanking and reset.
module tb_scan_counter_display;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int n;

  // Instance A: hex, 4 digits
  logic        a_rst_n, a_en, a_up, a_load, a_blank, a_tick;
  logic [15:0] a_load_val, a_value;
  logic [6:0]  a_seg;
  logic [3:0]  a_comm;
  // Instance B: BCD, 4 digits
  logic        b_rst_n, b_en, b_up, b_load, b_blank, b_tick;
  logic [15:0] b_load_val, b_value;
  logic [6:0]  b_seg;
  logic [3:0]  b_comm;
  // Instance C: 3 digits, scan timing
  logic        c_rst_n, c_en, c_up, c_load, c_blank, c_tick;
  logic [11:0] c_load_val, c_value;
  logic [6:0]  c_seg;
  logic [2:0]  c_comm;

  scan_counter_display #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_LOG2(3), .DECIMAL(0)) dut_a (
    .CLK(CLK), .RST_N(a_rst_n), .EN(a_en), .UP(a_up), .LOAD(a_load), .LOAD_VAL(a_load_val),
    .BLANK_LZ(a_blank), .SEG(a_seg), .COMM(a_comm), .VALUE(a_value), .TICK(a_tick));

  scan_counter_display #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_LOG2(4), .DECIMAL(1)) dut_b (
    .CLK(CLK), .RST_N(b_rst_n), .EN(b_en), .UP(b_up), .LOAD(b_load), .LOAD_VAL(b_load_val),
    .BLANK_LZ(b_blank), .SEG(b_seg), .COMM(b_comm), .VALUE(b_value), .TICK(b_tick));

  scan_counter_display #(.NUM_DIGITS(3), .TICK_DIV(4), .SCAN_LOG2(3), .DECIMAL(0)) dut_c (
    .CLK(CLK), .RST_N(c_rst_n), .EN(c_en), .UP(c_up), .LOAD(c_load), .LOAD_VAL(c_load_val),
    .BLANK_LZ(c_blank), .SEG(c_seg), .COMM(c_comm), .VALUE(c_value), .TICK(c_tick));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboards: expected VALUE after each TICK/LOAD cycle
  logic [15:0] sb_a[$];
  logic [15:0] sb_b[$];
  logic a_pend = 1'b0;
  logic b_pend = 1'b0;

  always @(negedge CLK) begin
    if (a_pend) begin
      if (sb_a.size() == 0) begin
        n_checks++;
        $display("FAIL sb_a: VALUE %h with no expected entry", a_value);
      end else chk("sb_a_value", {16'h0, a_value}, {16'h0, sb_a.pop_front()});
    end
    a_pend = a_rst_n && (a_tick || a_load);
    if (b_pend) begin
      if (sb_b.size() == 0) begin
        n_checks++;
        $display("FAIL sb_b: VALUE %h with no expected entry", b_value);
      end else chk("sb_b_value", {16'h0, b_value}, {16'h0, sb_b.pop_front()});
    end
    b_pend = b_rst_n && (b_tick || b_load);
  end

  // Called at posedge+1; returns posedges until TICK is seen (ends in the TICK cycle).
  task automatic wait_tick(input bit sel_b, output int cnt);
    logic t;
    cnt = 0;
    do begin
      @(posedge CLK); #1;
      cnt++;
      t = sel_b ? b_tick : a_tick;
    end while (!t && cnt < 64);
    if (!t) begin
      n_checks++;
      $display("FAIL tick_timeout: no TICK within %0d cycles, required one", cnt);
    end
  endtask

  task automatic load_a(input logic [15:0] v, input logic [15:0] exp);
    sb_a.push_back(exp);
    a_load_val = v; a_load = 1'b1;
    @(posedge CLK); #1;
    a_load = 1'b0;
  endtask

  task automatic load_b(input logic [15:0] v, input logic [15:0] exp);
    sb_b.push_back(exp);
    b_load_val = v; b_load = 1'b1;
    @(posedge CLK); #1;
    b_load = 1'b0;
  endtask

  task automatic tick_b(input logic [15:0] exp);
    int m;
    sb_b.push_back(exp);
    b_en = 1'b1;
    wait_tick(1'b1, m);
    @(posedge CLK); #1;
    b_en = 1'b0;
  endtask

  // Wait for digit i's common to go low on instance A and check its segments.
  task automatic chk_digit_a(input int i, input logic [6:0] exp);
    logic [3:0] ec;
    int m;
    ec = ~(4'b0001 << i);
    repeat (2) @(negedge CLK);
    m = 0;
    while (a_comm !== ec && m < 100) begin
      @(negedge CLK);
      m++;
    end
    chk($sformatf("comm_digit%0d", i), {28'h0, a_comm}, {28'h0, ec});
    chk($sformatf("seg_digit%0d", i), {25'h0, a_seg}, {25'h0, exp});
    @(posedge CLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] ec;
    a_rst_n = 0; a_en = 1; a_up = 1; a_load = 0; a_load_val = '0; a_blank = 0;
    b_rst_n = 0; b_en = 0; b_up = 1; b_load = 0; b_load_val = '0; b_blank = 0;
    c_rst_n = 0; c_en = 0; c_up = 1; c_load = 0; c_load_val = '0; c_blank = 0;

    #12;
    chk("rst_value", {16'h0, a_value}, 32'h0);
    chk("rst_comm",  {28'h0, a_comm},  32'hF);
    chk("rst_seg",   {25'h0, a_seg},   32'h0);
    chk("rst_tick",  {31'h0, a_tick},  32'h0);
    @(posedge CLK); #1;

    // Scan sequence on the 3-digit instance: 111, 110 x7, 111, 101 x7, 111, 011 x7, ...
    c_rst_n = 1;
    for (int k = 0; k < 72; k++) begin
      @(negedge CLK);
      if (k == 0) ec = 3'b111;
      else if (((k - 1) % 8) == 0) ec = 3'b111;
      else ec = ~(3'b001 << (((k - 1) / 8) % 3));
      chk("comm_scan", {29'h0, c_comm}, {29'h0, ec});
    end
    @(posedge CLK); #1;

    // Hex counting, tick period, wrap
    sb_a.push_back(16'h0001); sb_a.push_back(16'h0002); sb_a.push_back(16'h0003);
    a_rst_n = 1;
    wait_tick(1'b0, n); chk("first_tick", n, 3);
    wait_tick(1'b0, n); chk("tick_period", n, 4);
    wait_tick(1'b0, n); chk("tick_period", n, 4);
    @(posedge CLK); #1;
    load_a(16'hFFFF, 16'hFFFF);
    sb_a.push_back(16'h0000);
    wait_tick(1'b0, n); chk("tick_after_load", n, 3);

    // LOAD in the TICK cycle wins; divider restarts
    sb_a.push_back(16'h1234);
    wait_tick(1'b0, n); chk("tick_period", n, 4);
    a_load_val = 16'h1234; a_load = 1'b1;
    @(posedge CLK); #1;
    a_load = 1'b0;
    sb_a.push_back(16'h1235);
    wait_tick(1'b0, n); chk("tick_after_tick_load", n + 1, 4);
    @(posedge CLK); #1;
    a_en = 0;

    // Hex down wrap
    a_up = 0;
    load_a(16'h0000, 16'h0000);
    sb_a.push_back(16'hFFFF);
    a_en = 1;
    wait_tick(1'b0, n);
    @(posedge CLK); #1;
    a_en = 0; a_up = 1;

    // Segment patterns and leading-zero blanking
    a_blank = 1;
    load_a(16'h0050, 16'h0050);
    chk_digit_a(3, 7'h00); chk_digit_a(2, 7'h00); chk_digit_a(1, 7'h6D); chk_digit_a(0, 7'h3F);
    load_a(16'h0000, 16'h0000);
    chk_digit_a(3, 7'h00); chk_digit_a(2, 7'h00); chk_digit_a(1, 7'h00); chk_digit_a(0, 7'h3F);
    load_a(16'hC0DE, 16'hC0DE);
    chk_digit_a(3, 7'h39); chk_digit_a(2, 7'h3F); chk_digit_a(1, 7'h5E); chk_digit_a(0, 7'h79);
    a_blank = 0;
    load_a(16'h0050, 16'h0050);
    chk_digit_a(3, 7'h3F); chk_digit_a(0, 7'h3F);
    load_a(16'h789A, 16'h789A);
    chk_digit_a(3, 7'h07); chk_digit_a(2, 7'h7F); chk_digit_a(1, 7'h6F); chk_digit_a(0, 7'h77);
    load_a(16'hF45B, 16'hF45B);
    chk_digit_a(3, 7'h71); chk_digit_a(2, 7'h66); chk_digit_a(1, 7'h6D); chk_digit_a(0, 7'h7C);
    load_a(16'h1236, 16'h1236);
    chk_digit_a(3, 7'h06); chk_digit_a(2, 7'h5B); chk_digit_a(1, 7'h4F); chk_digit_a(0, 7'h7D);

    // Asynchronous reset mid-count
    load_a(16'h0042, 16'h0042);
    a_en = 1;
    @(posedge CLK); #1;
    @(posedge CLK); #3;
    a_rst_n = 0;
    #1;
    chk("async_rst_value", {16'h0, a_value}, 32'h0);
    chk("async_rst_comm",  {28'h0, a_comm},  32'hF);
    chk("async_rst_seg",   {25'h0, a_seg},   32'h0);
    chk("async_rst_tick",  {31'h0, a_tick},  32'h0);
    @(posedge CLK); #1;
    sb_a.push_back(16'h0001);
    a_rst_n = 1;
    wait_tick(1'b0, n); chk("first_tick_after_reset", n, 3);
    @(posedge CLK); #1;
    a_en = 0;
    repeat (3) @(posedge CLK); #1;

    // BCD instance
    b_rst_n = 1;
    @(posedge CLK); #1;
    b_up = 1;
    load_b(16'h0999, 16'h0999); tick_b(16'h1000);
    b_up = 0;
    load_b(16'h0000, 16'h0000); tick_b(16'h9999);
    b_up = 1;
    load_b(16'h9999, 16'h9999); tick_b(16'h0000);
    load_b(16'h0A0C, 16'h0909);
    load_b(16'hFFFF, 16'h9999);
    load_b(16'h1909, 16'h1909); tick_b(16'h1910);
    b_up = 0;
    load_b(16'h1000, 16'h1000); tick_b(16'h0999);
    repeat (3) @(posedge CLK); #1;

    chk("sb_a_drained", sb_a.size(), 0);
    chk("sb_b_drained", sb_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
